// File: rtl/serial_demux_8.sv
// serial_demux_8: bit-serial to WIDTH-bit word deserializer with a valid/ready word output.
// Optional macro SERIAL_DEMUX_PARITY_EN appends an even-parity bit to each frame and flags errors.
module serial_demux_8 #(
  parameter int WIDTH = 8,
`ifdef SERIAL_DEMUX_PARITY_EN
  localparam int SEL_W = $clog2(WIDTH) + 1,
  localparam int LAST  = WIDTH
`else
  localparam int SEL_W = $clog2(WIDTH),
  localparam int LAST  = WIDTH - 1
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             in_bit,
  output logic             in_ready,
  output logic [SEL_W-1:0] select,
  output logic [0:WIDTH-1] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             parity_err
);

  logic [SEL_W-1:0] sel_r;
  logic [SEL_W-1:0] sel_nxt_s;
  logic [0:WIDTH-1] asm_r;
  logic [0:WIDTH-1] asm_nxt_s;
  logic [0:WIDTH-1] data_r;
  logic             valid_r;
  logic             last_slot_s;
  logic             accept_s;
  logic             complete_s;
  logic             deliver_s;

  // Only the frame-completing bit can stall, and only while the buffered word is unconsumed.
  assign last_slot_s = (sel_r == SEL_W'(LAST));
  assign in_ready    = !(last_slot_s && valid_r && !out_ready);
  assign accept_s    = in_valid && in_ready;
  assign complete_s  = accept_s && last_slot_s;
  assign deliver_s   = valid_r && out_ready;

  assign select    = sel_r;
  assign out_data  = data_r;
  assign out_valid = valid_r;

  // Next select value and assembly contents for the bit accepted this cycle.
  always_comb begin
    sel_nxt_s = sel_r;
    asm_nxt_s = asm_r;
    if (accept_s) begin
      if (last_slot_s) begin
        sel_nxt_s = {SEL_W{1'b0}};
      end else begin
        sel_nxt_s = sel_r + SEL_W'(1'b1);
      end
      for (int i = 0; i < WIDTH; i++) begin
        if (sel_r == SEL_W'(i)) begin
          asm_nxt_s[i] = in_bit;
        end else begin
          asm_nxt_s[i] = asm_r[i];
        end
      end
    end else begin
      sel_nxt_s = sel_r;
      asm_nxt_s = asm_r;
    end
  end

  // Select counter and assembly register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_r <= {SEL_W{1'b0}};
      asm_r <= {WIDTH{1'b0}};
    end else begin
      sel_r <= sel_nxt_s;
      asm_r <= asm_nxt_s;
    end
  end

  // Output word register; a completing word may replace one being delivered on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_r  <= {WIDTH{1'b0}};
      valid_r <= 1'b0;
    end else if (complete_s) begin
      data_r  <= asm_nxt_s;
      valid_r <= 1'b1;
    end else if (deliver_s) begin
      valid_r <= 1'b0;
    end
  end

`ifdef SERIAL_DEMUX_PARITY_EN
  logic perr_r;

  function automatic logic odd_ones(input logic [0:WIDTH-1] d);
    odd_ones = ^d;
  endfunction

  // Parity flag loads with the word; the parity slot never writes the assembly register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perr_r <= 1'b0;
    end else if (complete_s) begin
      perr_r <= odd_ones(asm_r) ^ in_bit;
    end else if (deliver_s) begin
      perr_r <= 1'b0;
    end
  end

  assign parity_err = perr_r;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_serial_demux_8.sv
// Directed self-checking bench for serial_demux_8 (WIDTH=8); also covers SERIAL_DEMUX_PARITY_EN builds.
module tb_serial_demux_8;

`ifdef SERIAL_DEMUX_PARITY_EN
  localparam int SEL_W = 4;
  localparam int FRAME = 9;
`else
  localparam int SEL_W = 3;
  localparam int FRAME = 8;
`endif

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_bit;
  logic             in_ready;
  logic [SEL_W-1:0] select;
  logic [0:7]       out_data;
  logic             out_valid;
  logic             out_ready;
  logic             parity_err;

  int n_checks;
  int n_errors;

  serial_demux_8 #(.WIDTH(8)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_bit(in_bit),
    .in_ready(in_ready),
    .select(select),
    .out_data(out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .parity_err(parity_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Frame bit k of word w: data bits MSB first (first received lands in out_data[0]), then parity.
  function automatic logic frame_bit(input logic [7:0] w, input int k);
    if (k < 8) frame_bit = w[7-k];
    else       frame_bit = ^w;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Send the first nbits frame bits of w, with gap idle cycles between bits.
  task automatic send_frame(input logic [7:0] w, input int nbits, input int gap);
    for (int k = 0; k < nbits; k++) begin
      check_eq("sel_before_bit", 32'(select), 32'(k));
      in_valid = 1'b1;
      in_bit   = frame_bit(w, k);
      tick();
      in_valid = 1'b0;
      if (k < nbits - 1) begin
        repeat (gap) begin
          tick();
          check_eq("sel_hold_bubble", 32'(select), 32'(k + 1));
        end
      end
    end
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    in_valid  = 1'b0;
    in_bit    = 1'b0;
    out_ready = 1'b1;
    rst_n     = 1'b0;
    #12;
    check_eq("rst_select", 32'(select), 32'd0);
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_out_data", 32'(out_data), 32'd0);
    check_eq("rst_parity_err", 32'(parity_err), 32'd0);
    rst_n = 1'b1;
    #1;
    check_eq("rst_in_ready", 32'(in_ready), 32'd1);

    // Basic back-to-back word, valid for exactly one cycle.
    send_frame(8'hAA, FRAME, 0);
    check_eq("basic_valid", 32'(out_valid), 32'd1);
    check_eq("basic_data", 32'(out_data), 32'hAA);
    check_eq("basic_sel_wrap", 32'(select), 32'd0);
    check_eq("basic_perr", 32'(parity_err), 32'd0);
    tick();
    check_eq("basic_valid_drop", 32'(out_valid), 32'd0);

    // Same word with a bubble between bits.
    send_frame(8'hAA, FRAME, 1);
    check_eq("bubble_valid", 32'(out_valid), 32'd1);
    check_eq("bubble_data", 32'(out_data), 32'hAA);
    tick();
    check_eq("bubble_valid_drop", 32'(out_valid), 32'd0);

    // Backpressure: A held while B fills; only the completing bit of B stalls.
    out_ready = 1'b0;
    send_frame(8'hF0, FRAME, 0);
    check_eq("bp_a_valid", 32'(out_valid), 32'd1);
    check_eq("bp_a_data", 32'(out_data), 32'hF0);
    send_frame(8'h0F, FRAME - 1, 0);
    check_eq("bp_a_stable", 32'(out_data), 32'hF0);
    check_eq("bp_sel_last", 32'(select), 32'(FRAME - 1));
    in_valid = 1'b1;
    in_bit   = frame_bit(8'h0F, FRAME - 1);
    #1;
    check_eq("bp_in_ready_low", 32'(in_ready), 32'd0);
    tick();
    check_eq("bp_sel_stalled", 32'(select), 32'(FRAME - 1));
    check_eq("bp_a_still", 32'(out_data), 32'hF0);
    check_eq("bp_a_valid_still", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    #1;
    check_eq("bp_in_ready_high", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    check_eq("bp_b_valid", 32'(out_valid), 32'd1);
    check_eq("bp_b_data", 32'(out_data), 32'h0F);
    check_eq("bp_b_sel_wrap", 32'(select), 32'd0);
    tick();
    check_eq("bp_b_delivered", 32'(out_valid), 32'd0);

    // Simultaneous delivery of a pending word and completion of the next.
    out_ready = 1'b0;
    send_frame(8'h55, FRAME, 0);
    check_eq("sim_first_data", 32'(out_data), 32'h55);
    send_frame(8'h3C, FRAME - 1, 0);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_bit    = frame_bit(8'h3C, FRAME - 1);
    tick();
    in_valid = 1'b0;
    check_eq("sim_valid_kept", 32'(out_valid), 32'd1);
    check_eq("sim_data_new", 32'(out_data), 32'h3C);
    tick();
    check_eq("sim_valid_drop", 32'(out_valid), 32'd0);

    // Asynchronous reset mid-word discards both partial and pending words.
    out_ready = 1'b0;
    send_frame(8'hFF, FRAME, 0);
    send_frame(8'h5A, 5, 0);
    check_eq("mr_sel_before", 32'(select), 32'd5);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("mr_select", 32'(select), 32'd0);
    check_eq("mr_out_valid", 32'(out_valid), 32'd0);
    check_eq("mr_out_data", 32'(out_data), 32'd0);
    #1;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    tick();
    check_eq("mr_no_output", 32'(out_valid), 32'd0);
    send_frame(8'h81, FRAME, 0);
    check_eq("mr_new_valid", 32'(out_valid), 32'd1);
    check_eq("mr_new_data", 32'(out_data), 32'h81);
    tick();

`ifdef SERIAL_DEMUX_PARITY_EN
    // Good parity, then bad parity on the same data.
    send_frame(8'h07, 8, 0);
    in_valid = 1'b1;
    in_bit   = 1'b1;
    tick();
    in_valid = 1'b0;
    check_eq("par_ok_valid", 32'(out_valid), 32'd1);
    check_eq("par_ok_data", 32'(out_data), 32'h07);
    check_eq("par_ok_err", 32'(parity_err), 32'd0);
    tick();
    send_frame(8'h07, 8, 0);
    in_valid = 1'b1;
    in_bit   = 1'b0;
    tick();
    in_valid = 1'b0;
    check_eq("par_bad_valid", 32'(out_valid), 32'd1);
    check_eq("par_bad_data", 32'(out_data), 32'h07);
    check_eq("par_bad_err", 32'(parity_err), 32'd1);
    tick();
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
